// File: rtl/rgb_fader_if.sv
// rtl/rgb_fader_if.sv - target-load and status bundle for rgb_fader
interface rgb_fader_if;
    logic       i_load;
    logic [7:0] i_tgt_r;
    logic [7:0] i_tgt_g;
    logic [7:0] i_tgt_b;
    logic       o_busy;
    logic       o_done;

    modport master (output i_load, i_tgt_r, i_tgt_g, i_tgt_b, input o_busy, o_done);
    modport slave  (input i_load, i_tgt_r, i_tgt_g, i_tgt_b, output o_busy, o_done);
endinterface

// File: rtl/rgb_fader.sv
// rtl/rgb_fader.sv - three-channel LED fader driving 8-bit PWM outputs
// Optional squared-level gamma stage enabled by defining RGB_FADER_GAMMA_EN.
module rgb_fader #(
    parameter int STEP_TICKS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_stb,
    rgb_fader_if.slave bus,
    output logic       o_pwm_r,
    output logic       o_pwm_g,
    output logic       o_pwm_b
);
    typedef enum logic {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

    localparam logic [7:0] LAST_TICK = 8'(STEP_TICKS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0][7:0] r_level;
    logic [2:0][7:0] r_tgt;
    logic [2:0][7:0] r_duty;
    logic [2:0][7:0] w_duty_src;
    logic [2:0][7:0] w_tgt_in;
    logic [7:0]      r_pwm_cnt;
    logic [7:0]      r_tick_cnt;
    logic [2:0]      r_pwm;
    logic            r_done;
    logic            w_all_eq;
    logic            w_ramp_stb;
    logic            w_step;

    assign w_tgt_in   = {bus.i_tgt_b, bus.i_tgt_g, bus.i_tgt_r};
    assign w_all_eq   = (r_level == r_tgt);
    // A load in the same cycle as a strobe suppresses both the tick and the step.
    assign w_ramp_stb = (r_state == S_RAMP) && !bus.i_load && !w_all_eq && i_stb;
    assign w_step     = w_ramp_stb && (r_tick_cnt == LAST_TICK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.i_load) begin
            w_state_next = S_RAMP;
        end else if ((r_state == S_RAMP) && w_all_eq) begin
            w_state_next = S_IDLE;
        end
    end

    always_comb begin
        bus.o_busy = (r_state == S_RAMP);
        bus.o_done = r_done;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tgt      <= '0;
            r_level    <= '0;
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_RAMP) && !bus.i_load && w_all_eq;
            if (bus.i_load) begin
                r_tgt      <= w_tgt_in;
                r_tick_cnt <= '0;
            end else if (w_step) begin
                r_tick_cnt <= '0;
            end else if (w_ramp_stb) begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end
            for (int c = 0; c < 3; c++) begin
                if (w_step && (r_level[c] < r_tgt[c])) begin
                    r_level[c] <= r_level[c] + 8'd1;
                end else if (w_step && (r_level[c] > r_tgt[c])) begin
                    r_level[c] <= r_level[c] - 8'd1;
                end
            end
        end
    end

`ifdef RGB_FADER_GAMMA_EN
    logic [2:0][7:0] r_gam;

    function automatic logic [7:0] gamma8(input logic [7:0] lvl);
        logic [15:0] sq;
        sq = {8'd0, lvl} * {8'd0, lvl};
        return sq[15:8];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gam <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                r_gam[c] <= gamma8(r_level[c]);
            end
        end
    end

    assign w_duty_src = r_gam;
`else
    assign w_duty_src = r_level;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_duty    <= w_duty_src;
            for (int c = 0; c < 3; c++) begin
                r_pwm[c] <= (r_duty[c] > r_pwm_cnt);
            end
        end
    end

    assign o_pwm_r = r_pwm[0];
    assign o_pwm_g = r_pwm[1];
    assign o_pwm_b = r_pwm[2];
endmodule

// File: doc/rgb_fader.md
# rgb_fader

Three-channel LED fader for the Fomu (iCE40up5k) RGB LED. It consumes the 46.875 kHz strobe produced by the clock divider as its fade timebase. Each channel's brightness level ramps one step at a time toward a loaded target, and each level drives an 8-bit PWM output at 48 MHz / 256 = 187.5 kHz. The PWM outputs feed the RGB LED driver primitive directly.

## Interface

- `STEP_TICKS`, default 4: number of `i_stb` pulses per one-level fade step; legal range 1..255.
- `i_clk`  in  1  system clock, 48 MHz
- `i_rst`  in  1  reset; one clock; synchronous, active-high
- `i_stb`  in  1  fade timebase strobe, 46.875 kHz, 1-cycle pulse
- `i_load`  in  1  latch new targets, 1-cycle pulse
- `i_tgt_r`, `i_tgt_g`, `i_tgt_b`  in  8 each  target levels; sampled only when `i_load`=1
- `o_pwm_r`, `o_pwm_g`, `o_pwm_b`  out  1 each  registered PWM outputs
- `o_busy`  out  1  high while state is RAMP
- `o_done`  out  1  1-cycle pulse when a ramp completes

## Operation

- **Reset values:**
  - outputs: all `o_*` = 0
  - registers: levels = 0, targets = 0, `pwm_cnt` = 0, `tick_cnt` = 0, state = IDLE
- **PWM counter:**
  - `pwm_cnt` is 8 bits, increments every `i_clk`, wraps 255 -> 0.
  - `o_pwm_x` <= (`duty_x` > `pwm_cnt`), using an unsigned compare.
  - `duty_x` = 0 gives a constant low output.
  - `duty_x` = 255 gives high for 255 of every 256 cycles.
- **Fade state machine:**
  - IDLE: `o_busy`=0; `tick_cnt` held at 0.
  - `i_load` in any state:
    - latch all three targets
    - clear `tick_cnt`
    - next state = RAMP
    - no level step in that cycle (load wins over a coincident step)
  - RAMP, with no `i_load`:
    - If all levels equal their targets: next state = IDLE; `o_done`=1 in the following cycle only.
    - Otherwise, on `i_stb`:
      - If `tick_cnt` = `STEP_TICKS`-1: `tick_cnt` <= 0, and every channel with level ≠ target moves ±1 toward its target.
      - Otherwise: `tick_cnt` increments.
  - Levels are 8-bit and saturate naturally: a channel never steps past its target, so no wrap occurs.
- **Retargeting:** `i_load` mid-ramp retargets from the current levels with no jump. Channels already at their new target stay put.
- **Equal-target load:** loading targets equal to the current levels still passes through RAMP for exactly one cycle, then produces an `o_done` pulse.
- **Reset mid-ramp:** all levels go to 0 immediately; no `o_done` pulse is produced.

## Timing

- **`i_load` to `o_busy`:** `i_load` sampled at edge N gives `o_busy`=1 from N+1.
- **Equal-target load:** `o_done`=1 in cycle N+2 and `o_busy`=0 from N+2.
- **Fade step cadence:** one step every `STEP_TICKS` strobes. With the default of 4, a full 0 -> 255 ramp takes 255 × 4 × 1024 clocks ≈ 21.8 ms.
- **Step to PWM:** a level change is visible in `duty` one cycle after the step. The compare register adds one more cycle, so total level-to-`o_pwm` latency is 2 cycles. A new duty takes effect mid PWM period; no glitch-free period alignment is required.
- **`o_done` and `o_busy`:** `o_done` coincides with the first cycle of `o_busy`=0.

## Configuration

- **`RGB_FADER_GAMMA_EN` defined:**
  - `duty_x` = (`level_x` × `level_x`) >> 8, registered.
  - This adds one pipeline cycle, giving 3-cycle level-to-`o_pwm` latency.
  - Examples: level 0x80 -> duty 0x40; level 0xFF -> duty 0xFE; level 0x0F -> duty 0x00.
- **Macro undefined:** `duty_x` = `level_x` directly, with 2-cycle latency. No multiplier is inferred.

## Test plan

- **Reset:** assert `i_rst` for 2 cycles mid-ramp -> every output 0 from the next edge; `o_pwm_*` stays 0 for 512 cycles; no `o_done` pulse.
- **Basic ramp:** `STEP_TICKS`=1, load R=0x10, G=0x00, B=0x08 at 0 -> after 8 strobes B=0x08 and R=0x08; after 16 strobes R=0x10. `o_done` pulses once, 2 cycles after the 16th strobe; `o_busy` falls in the same cycle.
- **PWM duty:** levels settled at 0x80 -> each `o_pwm` is high for exactly 128 of any 256 consecutive cycles. Levels 0x00 -> never high. Levels 0xFF -> high 255 of 256.
- **Retarget:** load R=0x40, then after R reaches 0x20, load R=0x10 -> R decrements from 0x20 with no jump. Exactly one `o_done` pulse, when R=0x10.
- **Equal-target / coincident events:**
  - Load the current levels -> `o_busy` high for 1 cycle, `o_done` in cycle N+2.
  - `i_load` coincident with a step strobe -> no step that cycle; `tick_cnt` restarts.
- **Gamma (macro defined):** level 0x80 -> `o_pwm` high for 64 of 256 cycles; level 0xFF -> 254 of 256.
